pipeline_scoreboard: RTL

Parametrised Tnew/Tuse hazard scoreboard for the in-order MIPS pipeline. It replaces per-opcode stall and forward decoding with a shift register of in-flight destination entries, one slot per post-decode stage. It sits beside the ID stage. Each cycle it tells the top level whether to freeze PC and IF/ID (and bubble ID/EX), and for each ID-stage source which downstream stage will supply its value. Depth, register-file size and source-port count are generic, so the same block serves the 5-stage core and deeper variants.

---
 rtl/pipeline_scoreboard_pkg.sv | 44 ++++
 rtl/pipeline_scoreboard_slot.sv | 59 +++++
 rtl/pipeline_scoreboard.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipeline_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_scoreboard_pkg
// Brief   : Shared constants, entry type and helpers for the Tnew/Tuse
//           hazard scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_scoreboard_pkg;

  // Forward-select value meaning "take the operand from the register file"
  localparam int FWD_RF = 0;

  // Typical producer latencies (cycles after entering stage 1)
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;
  localparam int TNEW_LINK = 0;

  // Typical consumer latencies (cycles after ID until the operand is used)
  localparam int TUSE_ID  = 0;
  localparam int TUSE_EX  = 1;
  localparam int TUSE_MEM = 2;

  // Default field widths of a scoreboard entry for the 5-stage core
  localparam int SB_AW = 5;
  localparam int SB_TW = 2;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_TW-1:0] tnew;
  } sb_entry_t;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_scoreboard_slot.sv
`default_nettype none
// ============================================================================
// Module  : scoreboard_slot
// Brief   : One in-flight destination entry. Loads the upstream entry each
//           cycle, optionally decrementing Tnew with saturation at zero.
//           An invalid upstream entry is stored as an all-zero bubble.
// Revision: 1.0 - initial release
// ============================================================================
module scoreboard_slot #(
  parameter int AW  = 5,
  parameter int TW  = 2,
  parameter bit DEC = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic [TW-1:0] i_tnew,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [TW-1:0] o_tnew
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [TW-1:0] r_tnew;
  logic [TW-1:0] w_tnew_next;

  // Age the incoming Tnew by one stage, never wrapping below zero
  always_comb begin
    w_tnew_next = i_tnew;
    if (DEC && (i_tnew != '0)) begin
      w_tnew_next = i_tnew - TW'(1);
    end
  end

  // Entry register: take the upstream entry or become a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_tnew  <= '0;
    end else if (i_valid) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_tnew  <= w_tnew_next;
    end else begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_tnew  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_tnew  = r_tnew;

endmodule
`default_nettype wire

// File: rtl/pipeline_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_scoreboard
// Brief   : Tnew/Tuse hazard scoreboard beside the ID stage. Tracks in-flight
//           destinations in a shift register (slot k = stage k after ID),
//           raises stall when a source is needed before its producer's result
//           exists, and otherwise reports which stage to forward from.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter  int DEPTH = 3,
  parameter  int AW    = 5,
  parameter  int TW    = 2,
  parameter  int NSRC  = 2,
  localparam int SW    = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_id_valid,
  input  logic [NSRC*AW-1:0] i_id_src_addr,
  input  logic [NSRC-1:0]    i_id_src_used,
  input  logic [NSRC*TW-1:0] i_id_src_tuse,
  input  logic               i_id_dst_we,
  input  logic [AW-1:0]      i_id_dst_addr,
  input  logic [TW-1:0]      i_id_dst_tnew,
  input  logic               i_flush,
  output logic               o_stall,
  output logic [NSRC*SW-1:0] o_fwd_sel,
  output logic [NSRC-1:0]    o_fwd_rdy,
  output logic [DEPTH-1:0]   o_stage_valid,
  output logic [31:0]        o_stall_cnt
);

  // Slot index 0 holds stage 1 (EX), index DEPTH-1 holds stage DEPTH
  logic [DEPTH-1:0] w_slot_valid;
  logic [AW-1:0]    w_slot_addr [DEPTH];
  logic [TW-1:0]    w_slot_tnew [DEPTH];

  logic               w_load;
  logic               w_stall;
  logic [NSRC-1:0]    w_hz;
  logic [NSRC*SW-1:0] w_fwd_sel;
  logic [NSRC-1:0]    w_fwd_rdy;
  logic [31:0]        r_stall_cnt;

  // Only a real, unflushed, non-stalled writer of a nonzero register is tracked
  assign w_load = i_id_valid && i_id_dst_we && (i_id_dst_addr != '0) && !w_stall && !i_flush;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      if (k == 0) begin : g_head
        // Stage 1 takes the ID destination with its Tnew as given
        scoreboard_slot #(
          .AW  (AW),
          .TW  (TW),
          .DEC (1'b0)
        ) u_slot (
          .clk     (clk),
          .reset   (reset),
          .i_valid (w_load),
          .i_addr  (i_id_dst_addr),
          .i_tnew  (i_id_dst_tnew),
          .o_valid (w_slot_valid[k]),
          .o_addr  (w_slot_addr[k]),
          .o_tnew  (w_slot_tnew[k])
        );
      end else begin : g_body
        // Later stages shift the previous slot along, one Tnew closer
        scoreboard_slot #(
          .AW  (AW),
          .TW  (TW),
          .DEC (1'b1)
        ) u_slot (
          .clk     (clk),
          .reset   (reset),
          .i_valid (w_slot_valid[k-1]),
          .i_addr  (w_slot_addr[k-1]),
          .i_tnew  (w_slot_tnew[k-1]),
          .o_valid (w_slot_valid[k]),
          .o_addr  (w_slot_addr[k]),
          .o_tnew  (w_slot_tnew[k])
        );
      end
    end
  endgenerate

  // Per source: find the youngest matching producer. Scanning oldest to
  // youngest lets the youngest match overwrite any older one.
  always_comb begin
    w_hz      = '0;
    w_fwd_sel = '0;
    w_fwd_rdy = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_fwd_sel[i*SW +: SW] = SW'(FWD_RF);
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (i_id_src_used[i] && (i_id_src_addr[i*AW +: AW] != '0) &&
            w_slot_valid[k] && (w_slot_addr[k] == i_id_src_addr[i*AW +: AW])) begin
          w_fwd_sel[i*SW +: SW] = SW'(k + 1);
          w_fwd_rdy[i]          = (w_slot_tnew[k] == '0);
          w_hz[i]               = (w_slot_tnew[k] > i_id_src_tuse[i*TW +: TW]);
        end
      end
    end
  end

  assign w_stall = i_id_valid && (|w_hz);

  // Saturating count of stall cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall       = w_stall;
  assign o_fwd_sel     = w_fwd_sel;
  assign o_fwd_rdy     = w_fwd_rdy;
  assign o_stage_valid = w_slot_valid;
  assign o_stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
